// File: rtl/sensor_protocol_pkg.sv
// Shared command/response encodings and responder state codes.
// Also used by the host-side test model and the future sensor reader.
package sensor_protocol_pkg;

   localparam logic [7:0] CMD_STATUS      = 8'h00;
   localparam logic [7:0] CMD_TEMPERATURE = 8'h01;
   localparam logic [7:0] CMD_HUMIDITY    = 8'h02;

   localparam logic [7:0] RESP_SENSOR_OK    = 8'h07;
   localparam logic [7:0] RESP_HUMIDITY     = 8'h08;
   localparam logic [7:0] RESP_TEMPERATURE  = 8'h09;
   localparam logic [7:0] RESP_SENSOR_ERROR = 8'h1F;
   localparam logic [7:0] RESP_INVALID      = 8'hEF;

   typedef logic [3:0] state_t;

   localparam state_t S_IDLE        = 4'd0;
   localparam state_t S_WAIT_ADDR   = 4'd1;
   localparam state_t S_VALIDATE    = 4'd2;
   localparam state_t S_REQUEST     = 4'd3;
   localparam state_t S_WAIT_SENSOR = 4'd4;
   localparam state_t S_SEND_CODE   = 4'd5;
   localparam state_t S_WAIT_CODE   = 4'd6;
   localparam state_t S_SEND_DATA   = 4'd7;
   localparam state_t S_WAIT_DATA   = 4'd8;

   function automatic logic cmd_is_valid(input logic [7:0] cmd);
      return (cmd == CMD_STATUS) || (cmd == CMD_TEMPERATURE) || (cmd == CMD_HUMIDITY);
   endfunction

endpackage

// File: rtl/timeout_counter.sv
// Saturating cycle counter: held at zero by clear, flags expiry once count reaches limit.
module timeout_counter #(
   parameter int WIDTH = 18
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] limit,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

   assign expired = enable && !clear && (count >= limit);

endmodule

// File: rtl/uart_command_responder.sv
// Decodes {command, address} requests from the UART receiver, queries the sensor
// interface and returns a {response_code, payload} pair through the UART transmitter.
module uart_command_responder
   import sensor_protocol_pkg::*;
#(
   parameter int NUM_SENSORS    = 32,
   parameter int BYTE_TIMEOUT   = 50000,
   parameter int SENSOR_TIMEOUT = 100000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_has_data,
   input  logic [7:0] rx_data,
   output logic       tx_has_data,
   output logic [7:0] tx_data,
   input  logic       tx_is_transmitting,
   input  logic       tx_done,
   output logic       sensor_request,
   output logic [4:0] sensor_address,
   input  logic       sensor_ready,
   input  logic       sensor_error,
   input  logic [7:0] sensor_temperature,
   input  logic [7:0] sensor_humidity,
   output logic       busy
);

   localparam int MAX_TIMEOUT = (BYTE_TIMEOUT > SENSOR_TIMEOUT) ? BYTE_TIMEOUT : SENSOR_TIMEOUT;
   localparam int CW          = $clog2(MAX_TIMEOUT) + 1;
   localparam logic [8:0] NUM_SENSORS_W = 9'(NUM_SENSORS);

   state_t     state;
   logic [7:0] cmd;
   logic [7:0] addr;
   logic [7:0] code;
   logic [7:0] payload;

   logic          timer_enable;
   logic          timer_expired;
   logic [CW-1:0] timer_limit;

   // The two timed states are only entered from untimed ones, so holding the
   // counter cleared outside them restarts it on every entry.
   assign timer_enable = (state == S_WAIT_ADDR) || (state == S_WAIT_SENSOR);
   assign timer_limit  = (state == S_WAIT_ADDR) ? CW'(BYTE_TIMEOUT) : CW'(SENSOR_TIMEOUT);

   timeout_counter #(.WIDTH(CW)) u_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (!timer_enable),
      .enable  (timer_enable),
      .limit   (timer_limit),
      .expired (timer_expired)
   );

   assign busy = (state != S_IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         cmd            <= '0;
         addr           <= '0;
         code           <= '0;
         payload        <= '0;
         tx_has_data    <= 1'b0;
         tx_data        <= '0;
         sensor_request <= 1'b0;
         sensor_address <= '0;
      end else begin
         tx_has_data    <= 1'b0;
         sensor_request <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rx_has_data) begin
                  cmd   <= rx_data;
                  state <= S_WAIT_ADDR;
               end
            end
            S_WAIT_ADDR: begin
               // A byte arriving on the expiry cycle still completes the request.
               if (rx_has_data) begin
                  addr  <= rx_data;
                  state <= S_VALIDATE;
               end else if (timer_expired) begin
                  state <= S_IDLE;
               end
            end
            S_VALIDATE: begin
               if (!cmd_is_valid(cmd)) begin
                  code    <= RESP_INVALID;
                  payload <= cmd;
                  state   <= S_SEND_CODE;
               end else if ({1'b0, addr} >= NUM_SENSORS_W) begin
                  code    <= RESP_INVALID;
                  payload <= addr;
                  state   <= S_SEND_CODE;
               end else begin
                  sensor_request <= 1'b1;
                  sensor_address <= addr[4:0];
                  state          <= S_REQUEST;
               end
            end
            S_REQUEST: begin
               state <= S_WAIT_SENSOR;
            end
            S_WAIT_SENSOR: begin
               if (sensor_ready) begin
                  sensor_address <= '0;
                  state          <= S_SEND_CODE;
                  if (sensor_error) begin
                     code    <= RESP_SENSOR_ERROR;
                     payload <= '0;
                  end else if (cmd == CMD_TEMPERATURE) begin
                     code    <= RESP_TEMPERATURE;
                     payload <= sensor_temperature;
                  end else if (cmd == CMD_HUMIDITY) begin
                     code    <= RESP_HUMIDITY;
                     payload <= sensor_humidity;
                  end else begin
                     code    <= RESP_SENSOR_OK;
                     payload <= '0;
                  end
               end else if (timer_expired) begin
                  sensor_address <= '0;
                  code           <= RESP_SENSOR_ERROR;
                  payload        <= '0;
                  state          <= S_SEND_CODE;
               end
            end
            S_SEND_CODE: begin
               if (!tx_is_transmitting) begin
                  tx_has_data <= 1'b1;
                  tx_data     <= code;
                  state       <= S_WAIT_CODE;
               end
            end
            S_WAIT_CODE: begin
               if (tx_done) begin
                  state <= S_SEND_DATA;
               end
            end
            S_SEND_DATA: begin
               if (!tx_is_transmitting) begin
                  tx_has_data <= 1'b1;
                  tx_data     <= payload;
                  state       <= S_WAIT_DATA;
               end
            end
            S_WAIT_DATA: begin
               if (tx_done) begin
                  tx_data <= '0;
                  state   <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_command_responder.sv
// Scoreboard bench for uart_command_responder with behavioural transmitter and sensor models.
module tb_uart_command_responder;

   localparam int NUM_SENSORS    = 32;
   localparam int BYTE_TIMEOUT   = 50;
   localparam int SENSOR_TIMEOUT = 100;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rx_has_data = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       tx_has_data;
   logic [7:0] tx_data;
   logic       tx_is_transmitting = 1'b0;
   logic       tx_done = 1'b0;
   logic       sensor_request;
   logic [4:0] sensor_address;
   logic       sensor_ready = 1'b0;
   logic       sensor_error = 1'b0;
   logic [7:0] sensor_temperature = 8'h00;
   logic [7:0] sensor_humidity = 8'h00;
   logic       busy;

   uart_command_responder #(
      .NUM_SENSORS    (NUM_SENSORS),
      .BYTE_TIMEOUT   (BYTE_TIMEOUT),
      .SENSOR_TIMEOUT (SENSOR_TIMEOUT)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .rx_has_data        (rx_has_data),
      .rx_data            (rx_data),
      .tx_has_data        (tx_has_data),
      .tx_data            (tx_data),
      .tx_is_transmitting (tx_is_transmitting),
      .tx_done            (tx_done),
      .sensor_request     (sensor_request),
      .sensor_address     (sensor_address),
      .sensor_ready       (sensor_ready),
      .sensor_error       (sensor_error),
      .sensor_temperature (sensor_temperature),
      .sensor_humidity    (sensor_humidity),
      .busy               (busy)
   );

   // clock / reset
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // scoreboard state
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   int         tx_seen = 0;
   int         tx_left = 0;
   int         req_seen = 0;
   int         req_cyc = 0;
   int         byte_cyc = 0;
   logic [4:0] req_addr = 5'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // transmitter model, tx scoreboard and sensor_request monitor
   always @(negedge clock) begin
      if (reset) begin
         tx_is_transmitting = 1'b0;
         tx_done            = 1'b0;
         tx_left            = 0;
      end else begin
         tx_done = 1'b0;
         if (tx_has_data) begin
            tx_seen++;
            if (exp_q.size() == 0) check("tx_unexpected", {24'd0, tx_data}, 32'h100);
            else                   check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            tx_is_transmitting = 1'b1;
            tx_left            = $urandom_range(2, 6);
         end else if (tx_is_transmitting) begin
            if (tx_left == 0) begin
               tx_is_transmitting = 1'b0;
               tx_done            = 1'b1;
            end else begin
               tx_left--;
            end
         end
         if (sensor_request) begin
            req_seen++;
            req_addr = sensor_address;
            req_cyc  = cyc;
         end
      end
   end

   // driver tasks
   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      rx_data     = b;
      rx_has_data = 1'b1;
      byte_cyc    = cyc;
      @(negedge clock);
      rx_has_data = 1'b0;
   endtask

   task automatic wait_request(input string tag, input logic [4:0] addr);
      int start;
      int n;
      start = req_seen;
      n     = 0;
      while ((req_seen == start) && (n < 20)) begin
         @(negedge clock);
         n++;
      end
      check({tag, "_req"}, req_seen - start, 1);
      check({tag, "_lat"}, req_cyc - byte_cyc, 2);
      check({tag, "_addr"}, {27'd0, req_addr}, {27'd0, addr});
   endtask

   task automatic sensor_reply(input logic err, input logic [7:0] t, input logic [7:0] h);
      repeat (3) @(negedge clock);
      sensor_ready       = 1'b1;
      sensor_error       = err;
      sensor_temperature = t;
      sensor_humidity    = h;
      @(negedge clock);
      sensor_ready = 1'b0;
      sensor_error = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && (n < 400)) begin
         @(negedge clock);
         n++;
      end
      check({tag, "_idle"}, {31'd0, busy}, 0);
      check({tag, "_q_empty"}, exp_q.size(), 0);
   endtask

   task automatic wait_tx(input int start);
      int n;
      n = 0;
      while ((tx_seen == start) && (n < 50)) begin
         @(negedge clock);
         n++;
      end
   endtask

   // stimulus
   initial begin
      int r0;
      int t0;

      repeat (3) @(negedge clock);
      #1;
      check("reset_outputs",
            {16'd0, tx_has_data, tx_data, sensor_request, sensor_address, busy}, 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // temperature read of sensor 3
      exp_q.push_back(8'h09);
      exp_q.push_back(8'h19);
      send_byte(8'h01);
      send_byte(8'h03);
      wait_request("t1", 5'd3);
      sensor_reply(1'b0, 8'h19, 8'h55);
      wait_idle("t1");

      // sensor error overrides humidity command
      exp_q.push_back(8'h1F);
      exp_q.push_back(8'h00);
      send_byte(8'h02);
      send_byte(8'h00);
      wait_request("t2", 5'd0);
      sensor_reply(1'b1, 8'h22, 8'h33);
      wait_idle("t2");

      // bad command, then out-of-range address
      r0 = req_seen;
      exp_q.push_back(8'hEF);
      exp_q.push_back(8'h05);
      send_byte(8'h05);
      send_byte(8'h01);
      wait_idle("t3a");
      exp_q.push_back(8'hEF);
      exp_q.push_back(8'h20);
      send_byte(8'h00);
      send_byte(8'h20);
      wait_idle("t3b");
      check("t3_no_request", req_seen, r0);

      // highest valid address, humidity
      exp_q.push_back(8'h08);
      exp_q.push_back(8'hA7);
      send_byte(8'h02);
      send_byte(8'h1F);
      wait_request("t3c", 5'd31);
      sensor_reply(1'b0, 8'h11, 8'hA7);
      wait_idle("t3c");

      // byte timeout drops a half request silently
      t0 = tx_seen;
      send_byte(8'h01);
      repeat (BYTE_TIMEOUT - 8) @(negedge clock);
      check("t4_busy_before_timeout", {31'd0, busy}, 1);
      repeat (14) @(negedge clock);
      check("t4_idle_after_timeout", {31'd0, busy}, 0);
      check("t4_no_tx", tx_seen, t0);
      exp_q.push_back(8'h07);
      exp_q.push_back(8'h00);
      send_byte(8'h00);
      send_byte(8'h02);
      wait_request("t4", 5'd2);
      sensor_reply(1'b0, 8'h44, 8'h66);
      wait_idle("t4");

      // sensor timeout, late sensor_ready ignored
      exp_q.push_back(8'h1F);
      exp_q.push_back(8'h00);
      send_byte(8'h01);
      send_byte(8'h04);
      wait_request("t5", 5'd4);
      repeat (SENSOR_TIMEOUT - 10) @(negedge clock);
      check("t5_busy_waiting", {31'd0, busy}, 1);
      check("t5_no_tx_yet", exp_q.size(), 2);
      wait_idle("t5");
      t0 = tx_seen;
      sensor_reply(1'b0, 8'h77, 8'h88);
      repeat (10) @(negedge clock);
      check("t5_late_ready_busy", {31'd0, busy}, 0);
      check("t5_late_ready_no_tx", tx_seen, t0);

      // extra rx byte during a response is dropped
      exp_q.push_back(8'h08);
      exp_q.push_back(8'h44);
      send_byte(8'h02);
      send_byte(8'h07);
      wait_request("t6a", 5'd7);
      t0 = tx_seen;
      sensor_reply(1'b0, 8'h10, 8'h44);
      wait_tx(t0);
      send_byte(8'h01);
      wait_idle("t6a");
      repeat (5) @(negedge clock);
      check("t6a_extra_byte_dropped", {31'd0, busy}, 0);

      // reset while the response code is in flight
      exp_q.push_back(8'h09);
      send_byte(8'h01);
      send_byte(8'h06);
      wait_request("t6b", 5'd6);
      t0 = tx_seen;
      sensor_reply(1'b0, 8'h2A, 8'h00);
      wait_tx(t0);
      check("t6b_code_sent", tx_seen, t0 + 1);
      #2;
      reset = 1'b1;
      #1;
      check("t6b_reset_outputs",
            {16'd0, tx_has_data, tx_data, sensor_request, sensor_address, busy}, 0);
      check("t6b_q_empty", exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(negedge clock);
      reset = 1'b0;
      t0 = tx_seen;
      repeat (30) @(negedge clock);
      check("t6b_nothing_sent", tx_seen, t0);
      check("t6b_idle", {31'd0, busy}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
